// File: rtl/tage_hash_scheduler_if.sv
// Bundle of the request/grant handshakes, history-recovery inputs and
// generator-facing outputs of the TAGE hash scheduler.
//   slave  : scheduler view (takes requests, drives grants and generator controls)
//   master : requester/environment view (drives requests, observes grants)
interface tage_hash_scheduler_if #(
    parameter int GlobLen      = 131,
    parameter int ADDRESS_SIZE = 32
);
    logic                    pred_req;
    logic [ADDRESS_SIZE-1:0] pred_pc;
    logic                    pred_ack;
    logic                    upd_req;
    logic [ADDRESS_SIZE-1:0] upd_pc;
    logic                    upd_taken;
    logic                    upd_ack;
    logic                    ghist_load;
    logic [GlobLen-1:0]      ghist_in;
    logic [ADDRESS_SIZE-1:0] gen_pc_addr;
    logic [GlobLen-1:0]      gen_ghist;
    logic                    index_tag_enable;
    logic                    hash_valid;
    logic                    hash_is_upd;
    logic                    busy;

    modport slave (
        input  pred_req, pred_pc, upd_req, upd_pc, upd_taken, ghist_load, ghist_in,
        output pred_ack, upd_ack, gen_pc_addr, gen_ghist, index_tag_enable,
               hash_valid, hash_is_upd, busy
    );

    modport master (
        output pred_req, pred_pc, upd_req, upd_pc, upd_taken, ghist_load, ghist_in,
        input  pred_ack, upd_ack, gen_pc_addr, gen_ghist, index_tag_enable,
               hash_valid, hash_is_upd, busy
    );
endinterface

// File: rtl/tage_hash_scheduler.sv
// Sequencer/arbiter for the shared TAGE index/tag hash generator.
// Grants one of fetch (prediction) or retire (update) per 3-cycle slot,
// presents the granted PC and committed history to the generator, flags when
// the generator result is valid and owns the committed global history.
// Ports:
//   CLK    : clock
//   reset  : synchronous, active-low
//   bus    : tage_hash_scheduler_if.slave (requests, acks, history load,
//            generator PC/history/enable, hash_valid/hash_is_upd, busy)
module tage_hash_scheduler #(
    parameter int GlobLen        = 131,
    parameter int ADDRESS_SIZE   = 32,
    parameter int MAX_UPD_STREAK = 3
) (
    input  logic                  CLK,
    input  logic                  reset,
    tage_hash_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    owner_r;        // 1 = update owns the slot
    logic                    upd_taken_q_r;
    logic [3:0]              upd_streak_r;
    logic [ADDRESS_SIZE-1:0] gen_pc_r;
    logic [GlobLen-1:0]      ghist_r;

    logic                    grant_s;
    logic                    grant_upd_s;
    logic                    streak_cap_s;
    logic                    pred_ack_s;
    logic                    upd_ack_s;
    logic                    enable_s;
    logic                    valid_s;
    logic                    busy_s;

    // Arbitration: only decided in IDLE; prediction wins a tie once the
    // update streak has reached its cap, otherwise update wins.
    always_comb begin
        streak_cap_s = (upd_streak_r == 4'(MAX_UPD_STREAK));
        if (state_r == ST_IDLE) begin
            grant_s     = bus.pred_req | bus.upd_req;
            grant_upd_s = bus.upd_req & (~bus.pred_req | ~streak_cap_s);
        end else begin
            grant_s     = 1'b0;
            grant_upd_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE:  state_nxt_s = grant_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        pred_ack_s = 1'b0;
        upd_ack_s  = 1'b0;
        enable_s   = 1'b0;
        valid_s    = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_ISSUE: begin
                pred_ack_s = ~owner_r;
                upd_ack_s  = owner_r;
                enable_s   = 1'b1;
                busy_s     = 1'b1;
            end
            ST_DONE: begin
                valid_s = 1'b1;
                busy_s  = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Grant capture, update-streak tracking and committed history.
    // A recovery load overrides a concurrent shift on the same edge.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            gen_pc_r      <= {ADDRESS_SIZE{1'b0}};
            owner_r       <= 1'b0;
            upd_taken_q_r <= 1'b0;
            upd_streak_r  <= 4'd0;
            ghist_r       <= {GlobLen{1'b0}};
        end else begin
            if (grant_s) begin
                gen_pc_r <= grant_upd_s ? bus.upd_pc : bus.pred_pc;
                owner_r  <= grant_upd_s;
                if (grant_upd_s) begin
                    upd_taken_q_r <= bus.upd_taken;
                    upd_streak_r  <= bus.pred_req ? (upd_streak_r + 4'd1) : 4'd0;
                end else begin
                    upd_streak_r  <= 4'd0;
                end
            end
            if (bus.ghist_load) begin
                ghist_r <= bus.ghist_in;
            end else if ((state_r == ST_DONE) && owner_r) begin
                ghist_r <= {ghist_r[GlobLen-2:0], upd_taken_q_r};
            end
        end
    end

    assign bus.pred_ack         = pred_ack_s;
    assign bus.upd_ack          = upd_ack_s;
    assign bus.index_tag_enable = enable_s;
    assign bus.hash_valid       = valid_s;
    assign bus.hash_is_upd      = owner_r;
    assign bus.busy             = busy_s;
    assign bus.gen_pc_addr      = gen_pc_r;
    assign bus.gen_ghist        = ghist_r;

endmodule

// File: tb/tb_tage_hash_scheduler.sv
module tb_tage_hash_scheduler;
    localparam int GL   = 131;
    localparam int AS   = 32;
    localparam int MAXS = 3;

    logic CLK;
    logic reset;

    tage_hash_scheduler_if #(.GlobLen(GL), .ADDRESS_SIZE(AS)) bus ();

    tage_hash_scheduler #(.GlobLen(GL), .ADDRESS_SIZE(AS), .MAX_UPD_STREAK(MAXS)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: committed history and update streak, transaction level.
    logic [GL-1:0] m_ghist;
    int            m_streak;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [GL-1:0] obs, input logic [GL-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request slot, called at a negedge while the DUT is IDLE.
    // load_phase: 1 = recovery load during ISSUE, 2 = during DONE, other = none.
    task automatic transact(input string tag, input bit p, input bit u, input bit taken,
                            input bit hold, input int load_phase,
                            input logic [GL-1:0] load_val, output bit won_upd);
        logic [AS-1:0] ppc, upc, exp_pc;
        bit w;
        ppc = $urandom();
        upc = $urandom();
        bus.pred_req  = p;
        bus.upd_req   = u;
        bus.pred_pc   = ppc;
        bus.upd_pc    = upc;
        bus.upd_taken = taken;
        w = u && (!p || (m_streak != MAXS));
        if (w) m_streak = p ? m_streak + 1 : 0;
        else   m_streak = 0;
        exp_pc = w ? upc : ppc;
        won_upd = w;
        @(negedge CLK);  // ISSUE
        chk({tag, ".pred_ack"}, bus.pred_ack, !w);
        chk({tag, ".upd_ack"}, bus.upd_ack, w);
        chk({tag, ".enable"}, bus.index_tag_enable, 1'b1);
        chk({tag, ".issue_valid"}, bus.hash_valid, 1'b0);
        chkv({tag, ".gen_pc"}, GL'(bus.gen_pc_addr), GL'(exp_pc));
        chkv({tag, ".issue_ghist"}, bus.gen_ghist, m_ghist);
        if (!hold) begin
            if (w) bus.upd_req = 1'b0;
            else   bus.pred_req = 1'b0;
        end
        if (load_phase == 1) begin
            bus.ghist_load = 1'b1;
            bus.ghist_in   = load_val;
        end
        @(negedge CLK);  // DONE
        bus.ghist_load = 1'b0;
        if (load_phase == 1) m_ghist = load_val;
        chk({tag, ".valid"}, bus.hash_valid, 1'b1);
        chk({tag, ".is_upd"}, bus.hash_is_upd, w);
        chk({tag, ".done_ack"}, bus.pred_ack | bus.upd_ack, 1'b0);
        chk({tag, ".done_enable"}, bus.index_tag_enable, 1'b0);
        chkv({tag, ".done_ghist"}, bus.gen_ghist, m_ghist);
        if (load_phase == 2) begin
            bus.ghist_load = 1'b1;
            bus.ghist_in   = load_val;
        end
        @(negedge CLK);  // IDLE
        bus.ghist_load = 1'b0;
        if (load_phase == 2) m_ghist = load_val;
        else if (w)          m_ghist = {m_ghist[GL-2:0], taken};
        chk({tag, ".idle_busy"}, bus.busy, 1'b0);
        chk({tag, ".idle_valid"}, bus.hash_valid, 1'b0);
        chkv({tag, ".idle_ghist"}, bus.gen_ghist, m_ghist);
    endtask

    initial begin
        bit w;
        bit exp_order [8];
        logic [GL-1:0] ones;
        logic [GL-1:0] hold_g;
        logic [159:0]  rnd;

        exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ones = {GL{1'b1}};
        m_ghist  = '0;
        m_streak = 0;

        reset          = 1'b0;
        bus.pred_req   = 1'b0;
        bus.pred_pc    = '0;
        bus.upd_req    = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_taken  = 1'b0;
        bus.ghist_load = 1'b0;
        bus.ghist_in   = '0;
        repeat (3) @(negedge CLK);
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.valid", bus.hash_valid, 1'b0);
        chk("rst.ack", bus.pred_ack | bus.upd_ack, 1'b0);
        chk("rst.enable", bus.index_tag_enable, 1'b0);
        chkv("rst.ghist", bus.gen_ghist, '0);
        chkv("rst.pc", GL'(bus.gen_pc_addr), '0);
        reset = 1'b1;
        @(negedge CLK);

        // Single prediction at PC 0x1234 from empty history.
        bus.pred_req = 1'b1;
        bus.pred_pc  = 32'h0000_1234;
        @(negedge CLK);
        chk("pred1.ack", bus.pred_ack, 1'b1);
        chk("pred1.enable", bus.index_tag_enable, 1'b1);
        chkv("pred1.pc", GL'(bus.gen_pc_addr), GL'(32'h0000_1234));
        bus.pred_req = 1'b0;
        @(negedge CLK);
        chk("pred1.valid", bus.hash_valid, 1'b1);
        chk("pred1.is_upd", bus.hash_is_upd, 1'b0);
        chk("pred1.enable_off", bus.index_tag_enable, 1'b0);
        @(negedge CLK);
        chkv("pred1.ghist", bus.gen_ghist, '0);

        // Three updates 1,0,1 build history 0b101.
        transact("upd1", 1'b0, 1'b1, 1'b1, 1'b0, 0, '0, w);
        transact("upd2", 1'b0, 1'b1, 1'b0, 1'b0, 0, '0, w);
        transact("upd3", 1'b0, 1'b1, 1'b1, 1'b0, 0, '0, w);
        chkv("upd.ghist101", bus.gen_ghist, GL'(3'b101));

        // Starvation guard with both requests held continuously.
        for (int i = 0; i < 8; i++) begin
            transact($sformatf("starve%0d", i), 1'b1, 1'b1, 1'b1, 1'b1, 0, '0, w);
            chk($sformatf("starve%0d.order", i), w, exp_order[i]);
        end
        bus.pred_req = 1'b0;
        bus.upd_req  = 1'b0;

        // Recovery load on the DONE->IDLE edge of an update beats the shift.
        transact("ldshift", 1'b0, 1'b1, 1'b0, 1'b0, 2, ones, w);
        chkv("ldshift.ones", bus.gen_ghist, ones);

        // Reset while an update is in ISSUE.
        transact("prerst", 1'b1, 1'b1, 1'b1, 1'b1, 0, '0, w);
        bus.upd_taken = 1'b1;
        @(negedge CLK);
        chk("rstmid.issue_ack", bus.upd_ack, 1'b1);
        reset = 1'b0;
        @(negedge CLK);
        m_ghist  = '0;
        m_streak = 0;
        chk("rstmid.busy", bus.busy, 1'b0);
        chk("rstmid.valid", bus.hash_valid, 1'b0);
        chk("rstmid.ack", bus.pred_ack | bus.upd_ack, 1'b0);
        chkv("rstmid.ghist", bus.gen_ghist, '0);
        chkv("rstmid.streak", GL'(dut.upd_streak_r), '0);
        bus.pred_req = 1'b0;
        bus.upd_req  = 1'b0;
        reset = 1'b1;
        @(negedge CLK);
        chk("rstmid.after_valid", bus.hash_valid, 1'b0);
        chk("rstmid.after_busy", bus.busy, 1'b0);

        // Idle hold: nothing moves without requests.
        hold_g = bus.gen_ghist;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk($sformatf("idle%0d.busy", i), bus.busy, 1'b0);
            chk($sformatf("idle%0d.enable", i), bus.index_tag_enable, 1'b0);
            chkv($sformatf("idle%0d.ghist", i), bus.gen_ghist, hold_g);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            int r, ph, gap;
            r   = $urandom_range(1, 3);
            ph  = $urandom_range(0, 3);
            gap = $urandom_range(0, 2);
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            transact($sformatf("rnd%0d", i), r[0], r[1], 1'($urandom_range(0, 1)),
                     1'b0, ph, rnd[GL-1:0], w);
            bus.pred_req = 1'b0;
            bus.upd_req  = 1'b0;
            for (int g = 0; g < gap; g++) @(negedge CLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tage_hash_scheduler.md
# tage_hash_scheduler

Sequencer and arbiter for the shared TAGE index/tag hash generator. It accepts prediction-lookup requests from fetch and update requests from retire, and grants one requester at a time. For the granted requester it drives the PC and the committed global history into the generator and pulses the generator's enable. It flags when the generator's registered indices and tags are valid and which requester they belong to, and it owns the committed global-history shift register.

## Interface
Parameters:
- GlobLen, 131, global history length in bits.
- ADDRESS_SIZE, 32, PC width.
- MAX_UPD_STREAK, 3, maximum consecutive update grants while a prediction is pending; range 1..15.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-low.
- pred_req  in  1  prediction lookup request, level.
- pred_pc  in  ADDRESS_SIZE  lookup PC; must be held stable while pred_req=1.
- pred_ack  out  1  one-cycle grant pulse to fetch.
- upd_req  in  1  update request, level.
- upd_pc  in  ADDRESS_SIZE  retiring branch PC; must be held stable while upd_req=1.
- upd_taken  in  1  resolved direction; held with upd_req.
- upd_ack  out  1  one-cycle grant pulse to retire.
- ghist_load  in  1  misprediction recovery: overwrite history.
- ghist_in  in  GlobLen  recovery history value.
- gen_pc_addr  out  ADDRESS_SIZE  PC presented to the generator (registered).
- gen_ghist  out  GlobLen  committed history presented to the generator (registered).
- index_tag_enable  out  1  generator compute enable.
- hash_valid  out  1  generator outputs valid this cycle.
- hash_is_upd  out  1  qualifies hash_valid: 1 = update owner, 0 = prediction owner.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, DONE.
  - IDLE -> ISSUE when pred_req|upd_req; otherwise stay in IDLE.
  - ISSUE -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- Arbitration, evaluated only in IDLE:
  - Only one requester high: grant it.
  - Both high: grant update unless upd_streak == MAX_UPD_STREAK, in which case grant prediction.
- upd_streak counter, 4 bits:
  - Increments on an update grant while pred_req=1.
  - Clears on a prediction grant.
  - Clears on an update grant while pred_req=0.
  - Holds otherwise.
- On a grant, registered at the same edge:
  - gen_pc_addr <= granted PC.
  - owner <= granted requester.
  - upd_taken_q <= upd_taken when update is granted.
- index_tag_enable = (state == ISSUE).
- pred_ack = (state == ISSUE) & ~owner.
- upd_ack = (state == ISSUE) & owner.
- hash_valid = (state == DONE); hash_is_upd = owner.
- History register ghist, committed only; gen_ghist = ghist.
  - On the DONE->IDLE edge with owner=update: ghist <= {ghist[GlobLen-2:0], upd_taken_q}.
  - ghist_load=1, in any state: ghist <= ghist_in.
  - Load and shift on the same edge: load wins and no shift is applied.
- Requesters drop req during their ack cycle. A req still high in the next IDLE cycle is treated as a new request.
- Reset (reset=0 at an edge), in any state, takes priority over every other action:
  - state = IDLE, ghist = 0, gen_pc_addr = 0, owner = 0, upd_taken_q = 0, upd_streak = 0.
  - Resulting outputs: all acks = 0, index_tag_enable = 0, hash_valid = 0, busy = 0.
  - An operation in flight is dropped with no ack and no history shift.

## Timing
- E0 samples a request in IDLE.
- Cycle after E0 (ISSUE): ack=1, index_tag_enable=1, gen_pc_addr and gen_ghist stable.
- E1: the generator registers its outputs.
- Cycle after E1 (DONE): hash_valid=1; the generator's Index/Comp_tag outputs are valid.
- E2: history shift if owner=update; state returns to IDLE.
- Request-to-valid latency: 2 cycles. Maximum throughput: one hash per 3 cycles.
- A ghist_load during ISSUE takes effect after E1, so the generator has already sampled the old history. A load during ISSUE therefore does not corrupt the hash in flight.
- Requests arriving during ISSUE or DONE wait for IDLE; no ack is issued before then.

## Test plan
- Single prediction: pred_req=1, pred_pc=0x0000_1234, ghist=0.
  - Required: pred_ack one cycle later; index_tag_enable for exactly that cycle; hash_valid=1 with hash_is_upd=0 one cycle after that.
  - Required: ghist unchanged.
- Update shift: three back-to-back updates with upd_taken=1,0,1 from ghist=0.
  - Required: ghist=0b101 after the third DONE.
  - Required: gen_ghist equals 0, 1, 0b10 during the respective ISSUE cycles.
- Starvation guard: pred_req and upd_req held high continuously, MAX_UPD_STREAK=3.
  - Required grant order: U, U, U, P, U, U, U, P; each grant 3 cycles apart.
- Load versus shift: ghist_load=1, ghist_in=all-ones, asserted on the DONE->IDLE edge of an update with upd_taken=0.
  - Required: ghist=all-ones, with no shift applied.
- Reset mid-operation: reset=0 during ISSUE of an update.
  - Required: next cycle state IDLE, hash_valid=0, ghist=0, upd_streak=0; the update is never reported as valid.
- Idle hold: no requests for 10 cycles.
  - Required: busy=0, index_tag_enable=0, ghist constant.
